// File: rtl/vga_clock_timekeeper.sv
// Time-of-day source for the VGA clock: BCD 24-hour time advanced by a clk prescaler,
// debounced adjust buttons, and a snapshot of the time reloaded only at frame start.
module vga_clock_timekeeper #(
  parameter int CLK_HZ          = 31500000,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adj_hrs,
  input  logic       adj_min,
  input  logic       adj_sec,
  input  logic       frame_start,
  output logic [1:0] hrs_tens,
  output logic [3:0] hrs_units,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------- helpers
  function automatic logic is_59(input logic [2:0] t, input logic [3:0] u);
    return (t == 3'd5) && (u == 4'd9);
  endfunction

  function automatic logic [6:0] inc_mod60(input logic [2:0] t, input logic [3:0] u);
    logic [6:0] r;
    if (u == 4'd9) begin
      if (t == 3'd5) r = {3'd0, 4'd0};
      else           r = {t + 3'd1, 4'd0};
    end else begin
      r = {t, u + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [5:0] inc_mod24(input logic [1:0] t, input logic [3:0] u);
    logic [5:0] r;
    if ((t == 2'd2) && (u == 4'd3)) r = {2'd0, 4'd0};
    else if (u == 4'd9)             r = {t + 2'd1, 4'd0};
    else                            r = {t, u + 4'd1};
    return r;
  endfunction

  // ---------------------------------------------------------------- prescaler
  logic [PW-1:0] pre_cnt_r;
  logic          tick_s;

  assign tick_s = (pre_cnt_r == PRE_LAST);

  // free-running one-second prescaler, untouched by adjusts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= '0;
    end else if (tick_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1);
    end
  end

  // ---------------------------------------------------------------- buttons
  // index 0 = hours, 1 = minutes, 2 = seconds
  logic [2:0] btn_raw_s;
  logic [2:0] press_s;

  assign btn_raw_s = {adj_sec, adj_min, adj_hrs};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          press_r;
    logic [DW-1:0] db_cnt_r;

    // synchroniser, debounce counter and rising-edge press pulse
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_r  <= 1'b0;
        sync2_r  <= 1'b0;
        stable_r <= 1'b0;
        press_r  <= 1'b0;
        db_cnt_r <= '0;
      end else begin
        sync1_r <= btn_raw_s[i];
        sync2_r <= sync1_r;
        press_r <= 1'b0;
        if (sync2_r == stable_r) begin
          db_cnt_r <= '0;
        end else if (db_cnt_r == DB_LAST) begin
          stable_r <= sync2_r;
          press_r  <= sync2_r;
          db_cnt_r <= '0;
        end else begin
          db_cnt_r <= db_cnt_r + DW'(1);
        end
      end
    end

    assign press_s[i] = press_r;
  end

  // ---------------------------------------------------------------- live time
  logic [1:0] h_t_r, h_t_s;
  logic [3:0] h_u_r, h_u_s;
  logic [2:0] m_t_r, m_t_s;
  logic [3:0] m_u_r, m_u_s;
  logic [2:0] s_t_r, s_t_s;
  logic [3:0] s_u_r, s_u_s;

  // adjusts take priority over the tick; a coinciding tick increment is dropped
  always_comb begin
    h_t_s = h_t_r;
    h_u_s = h_u_r;
    m_t_s = m_t_r;
    m_u_s = m_u_r;
    s_t_s = s_t_r;
    s_u_s = s_u_r;
    if (|press_s) begin
      if (press_s[0]) {h_t_s, h_u_s} = inc_mod24(h_t_r, h_u_r);
      else            {h_t_s, h_u_s} = {h_t_r, h_u_r};
      if (press_s[1]) {m_t_s, m_u_s} = inc_mod60(m_t_r, m_u_r);
      else            {m_t_s, m_u_s} = {m_t_r, m_u_r};
      if (press_s[2]) {s_t_s, s_u_s} = inc_mod60(s_t_r, s_u_r);
      else            {s_t_s, s_u_s} = {s_t_r, s_u_r};
    end else if (tick_s) begin
      {s_t_s, s_u_s} = inc_mod60(s_t_r, s_u_r);
      if (is_59(s_t_r, s_u_r)) begin
        {m_t_s, m_u_s} = inc_mod60(m_t_r, m_u_r);
        if (is_59(m_t_r, m_u_r)) {h_t_s, h_u_s} = inc_mod24(h_t_r, h_u_r);
        else                     {h_t_s, h_u_s} = {h_t_r, h_u_r};
      end else begin
        {m_t_s, m_u_s} = {m_t_r, m_u_r};
        {h_t_s, h_u_s} = {h_t_r, h_u_r};
      end
    end else begin
      {h_t_s, h_u_s, m_t_s, m_u_s, s_t_s, s_u_s} =
        {h_t_r, h_u_r, m_t_r, m_u_r, s_t_r, s_u_r};
    end
  end

  // live time registers and the registered second pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_t_r    <= 2'd0;
      h_u_r    <= 4'd0;
      m_t_r    <= 3'd0;
      m_u_r    <= 4'd0;
      s_t_r    <= 3'd0;
      s_u_r    <= 4'd0;
      sec_tick <= 1'b0;
    end else begin
      h_t_r    <= h_t_s;
      h_u_r    <= h_u_s;
      m_t_r    <= m_t_s;
      m_u_r    <= m_u_s;
      s_t_r    <= s_t_s;
      s_u_r    <= s_u_s;
      sec_tick <= tick_s;
    end
  end

  // snapshot captures the pre-update live time so digits are stable per frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hrs_tens  <= 2'd0;
      hrs_units <= 4'd0;
      min_tens  <= 3'd0;
      min_units <= 4'd0;
      sec_tens  <= 3'd0;
      sec_units <= 4'd0;
    end else if (frame_start) begin
      hrs_tens  <= h_t_r;
      hrs_units <= h_u_r;
      min_tens  <= m_t_r;
      min_units <= m_u_r;
      sec_tens  <= s_t_r;
      sec_units <= s_u_r;
    end else begin
      hrs_tens  <= hrs_tens;
      hrs_units <= hrs_units;
      min_tens  <= min_tens;
      min_units <= min_units;
      sec_tens  <= sec_tens;
      sec_units <= sec_units;
    end
  end

endmodule
